// File: rtl/soc_system_sysid_ext.sv
// soc_system_sysid_ext: Avalon-MM sysid slave with scratch, user words and optional uptime counter (SYSID_UPTIME_EN)
module soc_system_sysid_ext #(
  parameter logic [31:0] SYSTEM_ID = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
  parameter logic [31:0] VERSION = 32'h0001_0000,
  parameter int NUM_USER = 4,
  parameter int ADDR_W = 5
) (
  input logic clock,
  input logic reset,
  input logic [ADDR_W-1:0] address,
  input logic read,
  input logic write,
  input logic [31:0] writedata,
  input logic [32*NUM_USER-1:0] user_data,
  output logic [31:0] readdata,
  output logic readdatavalid
);
`ifdef SYSID_UPTIME_EN
  localparam logic UPTIME_PRESENT = 1'b1;
`else
  localparam logic UPTIME_PRESENT = 1'b0;
`endif
  localparam logic [31:0] CAPABILITY = {16'h0, 8'(NUM_USER), 7'h0, UPTIME_PRESENT};
  logic wr;
  int a;
  int u;
  logic [31:0] rd_word;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] rdata_q, rdata_d;
  logic rvalid_q, rvalid_d;
`ifdef SYSID_UPTIME_EN
  logic [63:0] uptime_q, uptime_d;
  logic [31:0] shadow_q, shadow_d;
`endif
  always_comb begin
    a = int'(address);
    u = a - 8;
    wr = write && !read;
    rd_word = '0;
    case (a)
      0: rd_word = SYSTEM_ID;
      1: rd_word = TIMESTAMP;
      2: rd_word = VERSION;
      3: rd_word = scratch_q;
`ifdef SYSID_UPTIME_EN
      4: rd_word = uptime_q[31:0];
      5: rd_word = shadow_q;
`endif
      6: rd_word = CAPABILITY;
      default: rd_word = (u >= 0 && u < NUM_USER) ? user_data[32*u +: 32] : '0;
    endcase
    scratch_d = (wr && a == 3) ? writedata : scratch_q;
    rvalid_d = read;
    rdata_d = read ? rd_word : rdata_q;
`ifdef SYSID_UPTIME_EN
    uptime_d = (wr && a == 4) ? '0 : uptime_q + 64'd1;
    shadow_d = (read && a == 4) ? uptime_q[63:32] : shadow_q;
`endif
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      scratch_q <= '0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end
`ifdef SYSID_UPTIME_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      uptime_q <= '0;
      shadow_q <= '0;
    end else begin
      uptime_q <= uptime_d;
      shadow_q <= shadow_d;
    end
  end
`endif
  assign readdata = rdata_q;
  assign readdatavalid = rvalid_q && !reset;
endmodule

// File: tb/tb_soc_system_sysid_ext.sv
// tb_soc_system_sysid_ext: vector table, uptime corner sequences and randomized reference-model check
module tb_soc_system_sysid_ext;
  localparam logic [31:0] SID = 32'hA5A5_0001;
  localparam logic [31:0] TS = 32'h5630_2AFA;
  localparam logic [31:0] VER = 32'h0002_0003;
`ifdef SYSID_UPTIME_EN
  localparam bit UP = 1'b1;
`else
  localparam bit UP = 1'b0;
`endif
  localparam logic [31:0] CAP = {16'h0, 8'd4, 7'h0, UP};
  typedef struct {
    int r;
    int w;
    int rs;
    int a;
    logic [31:0] wd;
    int ev;
    logic [31:0] ed;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] addr;
  logic rd_i;
  logic wr_i;
  logic [31:0] wdata;
  logic [31:0] uw [4];
  logic [127:0] user_data;
  logic [31:0] readdata;
  logic readdatavalid;
  int nerr = 0;
  int nchk = 0;
  logic [31:0] m_scr, m_sh, m_rd;
  logic [63:0] m_up;
  bit m_rv;
  vec_t tbl[21];
  assign user_data = {uw[3], uw[2], uw[1], uw[0]};
  always #5 clk = ~clk;
  soc_system_sysid_ext #(
    .SYSTEM_ID(SID),
    .TIMESTAMP(TS),
    .VERSION(VER),
    .NUM_USER(4),
    .ADDR_W(5)
  ) dut (
    .clock(clk),
    .reset(rst),
    .address(addr),
    .read(rd_i),
    .write(wr_i),
    .writedata(wdata),
    .user_data(user_data),
    .readdata(readdata),
    .readdatavalid(readdatavalid)
  );
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask
  function automatic logic [31:0] word(input int a);
    if (a == 0) return SID;
    if (a == 1) return TS;
    if (a == 2) return VER;
    if (a == 3) return m_scr;
    if (a == 4) return UP ? m_up[31:0] : 32'h0;
    if (a == 5) return UP ? m_sh : 32'h0;
    if (a == 6) return CAP;
    if (a >= 8 && a < 12) return uw[a-8];
    return 32'h0;
  endfunction
  task automatic step(input int r, input int w, input int rs, input int a, input logic [31:0] wd);
    rd_i = r[0];
    wr_i = w[0];
    rst = rs[0];
    addr = a[4:0];
    wdata = wd;
    @(negedge clk);
    chk("model_valid", {31'b0, readdatavalid}, {31'b0, m_rv && rs == 0});
    chk("model_data", readdata, m_rd);
    if (rs != 0) begin
      m_rd = 0; m_rv = 0; m_scr = 0; m_up = 0; m_sh = 0;
    end else begin
      m_rv = (r != 0);
      if (r != 0) m_rd = word(a);
      if (r != 0 && a == 4) m_sh = m_up[63:32];
      if (w != 0 && r == 0 && a == 3) m_scr = wd;
      m_up = (UP && w != 0 && r == 0 && a == 4) ? 64'd0 : m_up + 64'd1;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; rd_i = 1'b0; wr_i = 1'b0; addr = '0; wdata = '0;
    uw[0] = 32'h1111_0000; uw[1] = 32'h2222_0001; uw[2] = 32'h0BAD_F00D; uw[3] = 32'h4444_0003;
    repeat (2) @(posedge clk);
    #1;
    m_scr = 0; m_up = 0; m_sh = 0; m_rd = 0; m_rv = 0;
    step(0, 0, 1, 0, 0);
    chk("reset_data", readdata, 32'h0);
    chk("reset_valid", {31'b0, readdatavalid}, 32'h0);
    tbl[0] = '{1, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 1, 0, 1, SID};
    tbl[2] = '{1, 0, 0, 2, 0, 1, TS};
    tbl[3] = '{1, 0, 0, 6, 0, 1, VER};
    tbl[4] = '{0, 1, 0, 3, 32'hDEAD_BEEF, 1, CAP};
    tbl[5] = '{1, 0, 0, 3, 0, 0, CAP};
    tbl[6] = '{0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF};
    tbl[7] = '{0, 0, 1, 0, 0, 0, 32'hDEAD_BEEF};
    tbl[8] = '{1, 0, 0, 3, 0, 0, 0};
    tbl[9] = '{1, 1, 0, 3, 32'h1234_5678, 1, 0};
    tbl[10] = '{1, 0, 0, 3, 0, 1, 0};
    tbl[11] = '{1, 0, 0, 12, 0, 1, 0};
    tbl[12] = '{1, 0, 0, 31, 0, 1, 0};
    tbl[13] = '{1, 0, 0, 7, 0, 1, 0};
    tbl[14] = '{0, 1, 0, 1, 32'hFFFF_FFFF, 1, 0};
    tbl[15] = '{1, 0, 0, 1, 0, 0, 0};
    tbl[16] = '{1, 0, 0, 10, 0, 1, TS};
    tbl[17] = '{1, 0, 1, 2, 0, 0, 32'h0BAD_F00D};
    tbl[18] = '{0, 0, 0, 0, 0, 0, 0};
    tbl[19] = '{1, 0, 0, 3, 0, 0, 0};
    tbl[20] = '{0, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 21; i++) begin
      rd_i = tbl[i].r[0];
      wr_i = tbl[i].w[0];
      rst = tbl[i].rs[0];
      addr = tbl[i].a[4:0];
      wdata = tbl[i].wd;
      #2;
      chk($sformatf("vec%0d_valid", i), {31'b0, readdatavalid}, 32'(tbl[i].ev));
      chk($sformatf("vec%0d_data", i), readdata, tbl[i].ed);
      step(tbl[i].r, tbl[i].w, tbl[i].rs, tbl[i].a, tbl[i].wd);
    end
`ifdef SYSID_UPTIME_EN
    force dut.uptime_q = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.uptime_q;
    m_up = 64'h0000_0000_FFFF_FFFF;
    step(1, 0, 0, 4, 0);
    chk("wrap_lo", readdata, 32'hFFFF_FFFF);
    step(1, 0, 0, 5, 0);
    chk("wrap_hi", readdata, 32'h0);
    step(1, 0, 0, 4, 0);
    chk("post_wrap_lo", readdata, 32'h1);
    step(1, 0, 0, 5, 0);
    chk("post_wrap_hi", readdata, 32'h1);
    step(0, 1, 0, 4, 32'hCAFE_0000);
    step(1, 0, 0, 4, 0);
    step(1, 0, 0, 4, 0);
    chk("clear_count", readdata, 32'h1);
`endif
    for (int i = 0; i < 400; i++) begin
      if ($urandom % 8 == 0) uw[$urandom % 4] = $urandom;
      step(int'($urandom % 2), int'($urandom % 3 == 0), int'($urandom % 40 == 0),
           ($urandom % 2 != 0) ? int'($urandom % 12) : int'($urandom % 32), $urandom);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
